nr_divider_seq: RTL and testbench

- Parametrised, iterative, unsigned non-restoring divider.
- Computes WIDTH-bit quotient and remainder over WIDTH/BITS_PER_CYCLE clock cycles.
- Uses valid/ready handshakes on input and output.
- Adds over the combinational array divider: a final remainder-correction step, divide-by-zero detection, output backpressure, and a configurable radix (bits per cycle). Sits in the arithmetic datapath wherever a shared, area-cheap divider is needed.

---
 rtl/nr_div_pkg.sv | 21 ++
 rtl/nr_div_step.sv | 24 ++
 rtl/nr_divider_seq.sv | 132 +++++++++++++
 tb/tb_nr_divider_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nr_div_pkg.sv
// Shared types and sizing helpers for the sequential non-restoring divider.
package nr_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int unsigned steps_per_div(input int unsigned width,
                                                input int unsigned bpc);
    return width / bpc;
  endfunction

  // Counter runs 0..steps-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring step: shift in a dividend bit, then add or subtract the divisor.
module nr_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] p,        // magnitude bits of partial remainder; sign comes in separately
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  input  logic             sign,
  output logic [WIDTH:0]   p_next_c,
  output logic             qbit_c
);

  logic [WIDTH:0] shifted_c;
  logic [WIDTH:0] operand_c;

  // Dropping the old sign bit is safe: the result is modulo 2^(WIDTH+1) and |P| < divisor.
  always_comb begin
    shifted_c = {p, dbit};
    operand_c = {1'b0, divisor};
    p_next_c  = sign ? (shifted_c + operand_c) : (shifted_c - operand_c);
    qbit_c    = ~p_next_c[WIDTH];
  end

endmodule

// File: rtl/nr_divider_seq.sv
// Iterative unsigned non-restoring divider with valid/ready handshakes and configurable radix.
module nr_divider_seq
  import nr_div_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  if ((WIDTH < 2) || (BITS_PER_CYCLE == 0) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("nr_divider_seq: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  localparam int unsigned STEPS = steps_per_div(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q_sr;
  logic [CW-1:0]    cnt;

  logic                      accept_c;
  logic                      zero_c;
  logic                      last_c;
  logic [WIDTH-1:0]          rem_fix_c;
  logic [BITS_PER_CYCLE-1:0] qbits_c;
  logic [WIDTH:0]            p_chain [BITS_PER_CYCLE+1];

  // Step chain: step 0 consumes the current dividend MSB.
  assign p_chain[0] = p;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    nr_div_step #(.WIDTH(WIDTH)) u_step (
      .p        (p_chain[i][WIDTH-1:0]),
      .dbit     (dvd[WIDTH-1-i]),
      .divisor  (dsr),
      .sign     (p_chain[i][WIDTH]),
      .p_next_c (p_chain[i+1]),
      .qbit_c   (qbits_c[BITS_PER_CYCLE-1-i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_c  = in_valid && in_ready;
    zero_c    = (divisor == '0);
    last_c    = (cnt == LAST);
    rem_fix_c = p[WIDTH] ? (p[WIDTH-1:0] + dsr) : p[WIDTH-1:0];
    case (state)
      IDLE: if (accept_c) state_nxt = zero_c ? DONE : RUN;
      RUN:  if (last_c) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags track the state being entered so they are valid right after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dsr         <= '0;
      p           <= '0;
      q_sr        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            dvd  <= dividend;
            dsr  <= divisor;
            p    <= '0;
            q_sr <= '0;
            cnt  <= '0;
            if (zero_c) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          p    <= p_chain[BITS_PER_CYCLE];
          dvd  <= dvd << BITS_PER_CYCLE;
          q_sr <= (q_sr << BITS_PER_CYCLE) | WIDTH'(qbits_c);
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          quotient  <= q_sr;
          remainder <= rem_fix_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_divider_seq.sv
// Self-checking bench: directed 16-bit radix-2 cases plus randomized 32-bit radix-4 traffic.
module tb_nr_divider_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv16, ir16, ov16, or16, z16;
  logic [15:0] dd16, ds16, q16, r16;
  logic        iv32, ir32, ov32, or32, z32;
  logic [31:0] dd32, ds32, q32, r32;

  nr_divider_seq #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .dividend(dd16), .divisor(ds16), .out_valid(ov16), .out_ready(or16),
    .quotient(q16), .remainder(r16), .div_by_zero(z16)
  );

  nr_divider_seq #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .dividend(dd32), .divisor(ds32), .out_valid(ov32), .out_ready(or32),
    .quotient(q32), .remainder(r32), .div_by_zero(z32)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones quotient and the dividend back.
  function automatic logic [63:0] ref_q(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] ones;
    ones = (64'd1 << w) - 64'd1;
    return (b == 64'd0) ? ones : (a / b);
  endfunction

  function automatic logic [63:0] ref_r(input logic [63:0] a, input logic [63:0] b);
    return (b == 64'd0) ? a : (a % b);
  endfunction

  // Issue one 16-bit division, measure edges from accept to out_valid, check results.
  task automatic div16(input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                       input logic [15:0] eq, input logic [15:0] er, input logic ez,
                       input bit release_out);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (!ir16 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready16 before issue", 64'(ir16), 64'd1);
    iv16 = 1'b1; dd16 = a; ds16 = b;
    @(posedge clk);
    #1;
    iv16 = 1'b0; dd16 = 16'($urandom); ds16 = 16'($urandom);
    lat = 0;
    while (!ov16 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency16", 64'(lat), 64'(exp_lat));
    chk("quotient16", 64'(q16), 64'(eq));
    chk("remainder16", 64'(r16), 64'(er));
    chk("div_by_zero16", 64'(z16), 64'(ez));
    chk("quotient16 vs model", 64'(q16), ref_q(64'(a), 64'(b), 16));
    chk("remainder16 vs model", 64'(r16), ref_r(64'(a), 64'(b)));
    chk("in_ready16 while done", 64'(ir16), 64'd0);
    if (release_out) begin
      or16 = 1'b1;
      @(posedge clk);
      #1;
      or16 = 1'b0;
      chk("out_valid16 after handshake", 64'(ov16), 64'd0);
      chk("in_ready16 after handshake", 64'(ir16), 64'd1);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          acc;
  } job_t;

  job_t jq[$];
  bit   seen32 = 1'b0;

  // Compare process: every cycle a 32-bit result is presented it must match the oldest job.
  always @(negedge clk) begin
    if (rst_n && ov32) begin
      if (jq.size() == 0) begin
        chk("out_valid32 with nothing pending", 64'(ov32), 64'd0);
      end else begin
        if (!seen32) begin
          seen32 = 1'b1;
          chk("latency32", 64'(cyc - jq[0].acc), (jq[0].b == 32'd0) ? 64'd0 : 64'd17);
        end
        chk("quotient32", 64'(q32), ref_q(64'(jq[0].a), 64'(jq[0].b), 32));
        chk("remainder32", 64'(r32), ref_r(64'(jq[0].a), 64'(jq[0].b)));
        chk("div_by_zero32", 64'(z32), 64'(jq[0].b == 32'd0));
        chk("in_ready32 while done", 64'(ir32), 64'd0);
        if (or32) begin
          void'(jq.pop_front());
          seen32 = 1'b0;
        end
      end
    end
  end

  // Random backpressure on the 32-bit consumer.
  initial begin
    or32 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      or32 = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int w;
    int hits;
    bit stalled;
    rst_n = 1'b0;
    iv16 = 1'b0; dd16 = '0; ds16 = '0; or16 = 1'b0;
    iv32 = 1'b0; dd32 = '0; ds32 = '0;
    #12;
    chk("reset in_ready16", 64'(ir16), 64'd1);
    chk("reset out_valid16", 64'(ov16), 64'd0);
    chk("reset quotient16", 64'(q16), 64'd0);
    chk("reset remainder16", 64'(r16), 64'd0);
    chk("reset div_by_zero16", 64'(z16), 64'd0);
    chk("reset in_ready32", 64'(ir32), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    div16(16'd90,   16'd33, 17, 16'd2,      16'd24,   1'b0, 1'b1);
    div16(16'd901,  16'd300, 17, 16'd3,     16'd1,    1'b0, 1'b1);
    div16(16'd5,    16'd7,  17, 16'd0,      16'd5,    1'b0, 1'b1);
    div16(16'd1234, 16'd0,  0,  16'hFFFF,   16'd1234, 1'b1, 1'b1);
    div16(16'd100,  16'd10, 17, 16'd10,     16'd0,    1'b0, 1'b1);

    // Output backpressure: result and flags must hold while the consumer stalls.
    div16(16'hFFFF, 16'd1, 17, 16'hFFFF, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall out_valid16", 64'(ov16), 64'd1);
      chk("stall quotient16", 64'(q16), 64'hFFFF);
      chk("stall remainder16", 64'(r16), 64'd0);
      chk("stall in_ready16", 64'(ir16), 64'd0);
    end
    or16 = 1'b1;
    @(posedge clk);
    #1;
    or16 = 1'b0;
    chk("release out_valid16", 64'(ov16), 64'd0);
    chk("release in_ready16", 64'(ir16), 64'd1);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    iv16 = 1'b1; dd16 = 16'd60000; ds16 = 16'd7;
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrun reset out_valid16", 64'(ov16), 64'd0);
    chk("midrun reset quotient16", 64'(q16), 64'd0);
    chk("midrun reset remainder16", 64'(r16), 64'd0);
    chk("midrun reset div_by_zero16", 64'(z16), 64'd0);
    chk("midrun reset in_ready16", 64'(ir16), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ov16) hits++;
    end
    chk("aborted division produced no result", 64'(hits), 64'd0);
    div16(16'd60000, 16'd7, 17, 16'd8571, 16'd3, 1'b0, 1'b1);

    // Randomized 32-bit traffic with in_valid held high back-to-back.
    stalled = 1'b0;
    for (int n = 0; n < 1000 && !stalled; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = 32'hFFFF_FFFF; b = 32'd1; end
        3: b = 32'($urandom_range(1, 255));
        4: begin
          if (b == 32'd0) b = 32'd1;
          a = a % b;
        end
        default: ;
      endcase
      iv32 = 1'b1; dd32 = a; ds32 = b;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!ir32 && w < 200);
      if (!ir32) begin
        chk("accept32 timeout", 64'(ir32), 64'd1);
        stalled = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        jq.push_back('{a: a, b: b, acc: cyc});
      end
    end
    iv32 = 1'b0;
    w = 0;
    while (jq.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain32 pending jobs", 64'(jq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
